gf2m_digit_serial_mult: RTL

- Parametrised, sequential GF(2^M) multiplier computing p = a·b mod g(x), MSB-first, D bits of b per clock.
- Successor to the fixed 32-bit combinational row: the same row recurrence (t·g ⊕ b·a ⊕ shifted p) is cascaded D-deep and iterated over ceil(M/D) cycles.
- Adds a run-time field polynomial, operand/result valid-ready handshakes and a controlling FSM.
- Sits between the operand source and the result consumer in the finite-field datapath.

---
 rtl/gf2m_pkg.sv | 36 +++
 rtl/gf2m_digit_rows.sv | 27 ++
 rtl/gf2m_digit_serial_mult.sv | 95 +++++++++
 3 files changed

// File: rtl/gf2m_pkg.sv
// rtl/gf2m_pkg.sv - shared types and row recurrence for the GF(2^M) digit-serial multiplier
package gf2m_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest field the row helper supports; narrower fields are masked down.
  localparam int MAX_M = 64;

  // Digit counter width: clog2 of the digit count, never below one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

  // One MSB-first row: shift p, fold the overflowing x^M term back in via g,
  // then add a when the current b bit is set. Result is masked to m bits.
  function automatic logic [MAX_M-1:0] gf2m_row_step(
    input logic [MAX_M-1:0] p,
    input logic [MAX_M-1:0] a,
    input logic [MAX_M-1:0] g,
    input logic             bbit,
    input int               m
  );
    logic [MAX_M-1:0] mask;
    logic [MAX_M-1:0] r;
    mask = (m >= MAX_M) ? {MAX_M{1'b1}} : ((64'd1 << m) - 64'd1);
    r    = {p[MAX_M-2:0], 1'b0};
    if (p[6'(m - 1)]) r = r ^ g;
    if (bbit) r = r ^ a;
    return r & mask;
  endfunction

endpackage

// File: rtl/gf2m_digit_rows.sv
// rtl/gf2m_digit_rows.sv - D cascaded GF(2^M) row steps, one digit of b per pass
module gf2m_digit_rows #(
  parameter int M = 32,
  parameter int D = 4
) (
  input  logic [M-1:0] p,
  input  logic [M-1:0] a,
  input  logic [M-1:0] g,
  input  logic [D-1:0] digit,
  output logic [M-1:0] p_next
);
  import gf2m_pkg::*;

  // chain[0] is the incoming partial product; chain[i+1] has absorbed i+1 digit bits.
  logic [M-1:0] chain [D+1];

  assign chain[0] = p;

  // Highest digit bit is the highest remaining b bit, so it is consumed first.
  for (genvar i = 0; i < D; i++) begin : g_row
    assign chain[i+1] = M'(gf2m_row_step(MAX_M'(chain[i]), MAX_M'(a), MAX_M'(g),
                                         digit[D-1-i], M));
  end

  assign p_next = chain[D];

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// rtl/gf2m_digit_serial_mult.sv - sequential GF(2^M) multiplier, D bits of b per clock, valid/ready
module gf2m_digit_serial_mult #(
  parameter int M = 32,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] ai,
  input  logic [M-1:0] bi,
  input  logic [M-1:0] gi,
  output logic [M-1:0] po,
  output logic         out_valid,
  input  logic         out_ready
);
  import gf2m_pkg::*;

  localparam int NDIG = (M + D - 1) / D;
  localparam int BW   = NDIG * D;
  localparam int CW   = cnt_width(NDIG);

  state_t          state;
  logic [M-1:0]    a_r;
  logic [M-1:0]    g_r;
  logic [M-1:0]    p_r;
  logic [BW-1:0]   b_r;
  logic [CW-1:0]   cnt;
  logic [M-1:0]    p_next;
  logic            last;

  assign last = (cnt == CW'(NDIG - 1));

  gf2m_digit_rows #(
    .M(M),
    .D(D)
  ) u_rows (
    .p      (p_r),
    .a      (a_r),
    .g      (g_r),
    .digit  (b_r[BW-1 -: D]),
    .p_next (p_next)
  );

  // Control FSM with registered handshake outputs; b is zero-padded at the MSB
  // end so every digit is full width (padding rows leave p at zero).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      po        <= '0;
      a_r       <= '0;
      g_r       <= '0;
      p_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= ai;
            g_r      <= gi;
            b_r      <= BW'(bi);
            p_r      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          p_r <= p_next;
          b_r <= b_r << D;
          cnt <= cnt + CW'(1);
          if (last) begin
            po        <= p_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
